secuenciador_operandos: RTL and testbench
=========================================

Name: secuenciador_operandos

Overview:
Fetch/issue sequencer sitting directly upstream of the ALU and downstream of the operand ROMs (memory A and memory B, 8x32, combinational read). On start it walks addresses 0..N-1, drives the shared read address, and registers the A/B operands. It presents each operand pair to the ALU with a valid/ready handshake, then writes each ALU result to a result-store port.

Parameters:
ADDR_W, 3, operand ROM address width (depth 2**ADDR_W = 8)
DATA_W, 32, operand/result width

Ports:
clk_i  input  1  clock, all state on rising edge
rst_n_i  input  1  reset, asynchronous assert, active-low
start_i  input  1  start pulse; sampled only in IDLE
num_i  input  ADDR_W+1  number of entries to process (0..8)
addr_o  output  ADDR_W  read address to memory A and memory B
operador_a_i  input  DATA_W  memory A read data (combinational from addr_o)
operador_b_i  input  DATA_W  memory B read data
a_o  output  DATA_W  registered operand A to ALU
b_o  output  DATA_W  registered operand B to ALU
valid_o  output  1  a_o/b_o valid
ready_i  input  1  ALU/consumer accepts pair this cycle
resultado_i  input  DATA_W  ALU result (combinational from a_o/b_o)
wr_en_o  output  1  result write strobe, one cycle
wr_addr_o  output  ADDR_W  result write address (= entry index)
wr_data_o  output  DATA_W  registered result
busy_o  output  1  high in every state except IDLE
done_o  output  1  one-cycle pulse at end of run

Behaviour:
- Reset: one clock clk_i; rst_n_i low asynchronously forces state IDLE; idx, count, addr_o, a_o, b_o, wr_addr_o, wr_data_o = 0; valid_o, wr_en_o, busy_o, done_o = 0. Reset mid-run abandons the run, with no done_o and no wr_en_o.
- States: IDLE, FETCH, ISSUE, DONE.
- IDLE: when start_i=1, latch count = min(num_i, 8).
  - count==0: go to DONE.
  - Otherwise: idx=0, go to FETCH.
  - start_i in any other state: ignored.
- FETCH (1 cycle): addr_o=idx. At clock edge, a_o<=operador_a_i, b_o<=operador_b_i. Go to ISSUE.
- ISSUE:
  - valid_o=1; a_o/b_o held stable while ready_i=0 (no timeout).
  - On a cycle with valid_o&ready_i: wr_data_o<=resultado_i, wr_addr_o<=idx, wr_en_o=1 the next cycle (exactly one cycle).
  - Then, if idx==count-1: go to DONE. Else: idx<=idx+1, go to FETCH.
- DONE (1 cycle): done_o=1, busy_o=1, go to IDLE. done_o coincides with the last wr_en_o when count>0.
- addr_o holds its last value outside FETCH. valid_o=0 outside ISSUE.
- Throughput: 2 cycles per entry minimum (FETCH+ISSUE, ready_i tied high). Run of N entries with ready_i=1: busy_o high for 2N+1 cycles.
- Widths: idx is ADDR_W bits. count is ADDR_W+1 bits so 8 is representable. No wrap past idx=7, because num_i>8 is saturated to 8.

Decomposition:
- Shared package pkg_secuenciador: state encoding constants (IDLE=2'd0, FETCH=2'd1, ISSUE=2'd2, DONE=2'd3), ADDR_W/DATA_W defaults, MAX_ENTRIES=8.
- One natural sub-module: registro_operandos, a DATA_W-wide register pair with load enable and async active-low clear. Used for the a_o/b_o capture and reused for wr_data_o.

Test Plan:
- Single entry: memory A[0]=32'h350F6992, B[0]=32'h00000001, ALU=add model, num_i=1, start_i pulse, ready_i=1.
  -> addr_o=0 in FETCH; valid_o one cycle with a_o=32'h350F6992, b_o=1; then wr_en_o with wr_addr_o=0, wr_data_o=32'h350F6993, same cycle as done_o; busy_o high 3 cycles.
- Full run: num_i=8, A[i]=i, B[i]=10*i, ready_i=1.
  -> 8 wr_en_o pulses every 2 cycles; wr_addr_o 0..7; wr_data_o=11*i; done_o on cycle 17 after start.
- Backpressure: num_i=2, ready_i low for 5 cycles during the first ISSUE.
  -> valid_o held, a_o/b_o unchanged for 5 cycles, no wr_en_o; then normal completion with 2 writes.
- Boundaries:
  - num_i=0 -> done_o one cycle after start, no valid_o, no wr_en_o.
  - num_i=9 -> exactly 8 writes, last wr_addr_o=7.
- Start while busy: second start_i pulse mid-run (num_i changed to 3).
  -> ignored; original count honoured.
- Reset mid-run: rst_n_i low asynchronously during ISSUE of entry 4.
  -> all outputs 0 immediately (before next edge), state IDLE, no done_o. A new start then runs from addr 0.

Source files
------------

// File: rtl/secuenciador_operandos_pkg.sv
// Shared definitions for the operand fetch/issue sequencer: state encoding and
// default geometry of the operand ROMs.
package pkg_secuenciador;

    localparam int ADDR_W_DEF  = 3;
    localparam int DATA_W_DEF  = 32;
    localparam int MAX_ENTRIES = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } estado_t;

endpackage

// File: rtl/secuenciador_operandos_registro.sv
// Bank of NUM registers, WIDTH bits each, sharing one load enable and an
// asynchronous active-low clear.
module registro_operandos #(
    parameter int NUM   = 2,
    parameter int WIDTH = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       ld_i,
    input  logic [NUM-1:0][WIDTH-1:0]  d_i,
    output logic [NUM-1:0][WIDTH-1:0]  q_o
);

    logic [NUM-1:0][WIDTH-1:0] q_q, q_d;

    always_comb begin
        q_d = ld_i ? d_i : q_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) q_q <= '0;
        else          q_q <= q_d;
    end

    assign q_o = q_q;

endmodule

// File: rtl/secuenciador_operandos.sv
// Walks operand ROM addresses 0..N-1, issues each A/B pair to the ALU with a
// valid/ready handshake and writes every accepted result to the store port.
module secuenciador_operandos
    import pkg_secuenciador::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic [ADDR_W:0]   num_i,
    output logic [ADDR_W-1:0] addr_o,
    input  logic [DATA_W-1:0] operador_a_i,
    input  logic [DATA_W-1:0] operador_b_i,
    output logic [DATA_W-1:0] a_o,
    output logic [DATA_W-1:0] b_o,
    output logic              valid_o,
    input  logic              ready_i,
    input  logic [DATA_W-1:0] resultado_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(2**ADDR_W);

    estado_t           st_q, st_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic              wr_en_q, wr_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ld_ab, ld_res, es_ultimo;

    logic [1:0][DATA_W-1:0] ab_q;
    logic [0:0][DATA_W-1:0] res_q;

    assign es_ultimo = ({1'b0, idx_q} == cnt_q - 1'b1);

    always_comb begin
        st_d      = st_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        wr_addr_d = wr_addr_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        ld_ab     = 1'b0;
        ld_res    = 1'b0;
        case (st_q)
            IDLE: begin
                if (start_i) begin
                    cnt_d = (num_i > MAX_CNT) ? MAX_CNT : num_i;
                    if (num_i == '0) begin
                        st_d = DONE;
                    end else begin
                        idx_d  = '0;
                        addr_d = '0;
                        st_d   = FETCH;
                    end
                end
            end
            FETCH: begin
                ld_ab = 1'b1;
                st_d  = ISSUE;
            end
            ISSUE: begin
                if (ready_i) begin
                    ld_res    = 1'b1;
                    wr_addr_d = idx_q;
                    wr_en_d   = 1'b1;
                    if (es_ultimo) begin
                        st_d = DONE;
                    end else begin
                        // addr moves together with idx so the ROMs are settled by the FETCH edge
                        idx_d  = idx_q + 1'b1;
                        addr_d = idx_q + 1'b1;
                        st_d   = FETCH;
                    end
                end
            end
            default: st_d = IDLE;
        endcase
        // status flags are registered decodes of the next state
        valid_d = (st_d == ISSUE);
        busy_d  = (st_d != IDLE);
        done_d  = (st_d == DONE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            st_q      <= IDLE;
            idx_q     <= '0;
            addr_q    <= '0;
            wr_addr_q <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            st_q      <= st_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            wr_addr_q <= wr_addr_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            wr_en_q   <= wr_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    registro_operandos #(.NUM(2), .WIDTH(DATA_W)) u_reg_ab (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .ld_i    (ld_ab),
        .d_i     ({operador_a_i, operador_b_i}),
        .q_o     (ab_q)
    );

    registro_operandos #(.NUM(1), .WIDTH(DATA_W)) u_reg_res (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .ld_i    (ld_res),
        .d_i     (resultado_i),
        .q_o     (res_q)
    );

    assign addr_o    = addr_q;
    assign a_o       = ab_q[1];
    assign b_o       = ab_q[0];
    assign valid_o   = valid_q;
    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = res_q[0];
    assign busy_o    = busy_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_secuenciador_operandos.sv
// Directed bench for secuenciador_operandos: ROM and adder-ALU models around
// the DUT, hand-computed expectations checked with immediate assertions.
module tb_secuenciador_operandos;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start_i = 1'b0;
    logic [3:0]  num_i = '0;
    logic [2:0]  addr_o;
    logic [31:0] operador_a_i, operador_b_i;
    logic [31:0] a_o, b_o;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic [31:0] resultado_i;
    logic        wr_en_o;
    logic [2:0]  wr_addr_o;
    logic [31:0] wr_data_o;
    logic        busy_o, done_o;

    logic [31:0] mem_a [8];
    logic [31:0] mem_b [8];

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    assign operador_a_i = mem_a[addr_o];
    assign operador_b_i = mem_b[addr_o];
    assign resultado_i  = a_o + b_o;

    secuenciador_operandos dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .start_i      (start_i),
        .num_i        (num_i),
        .addr_o       (addr_o),
        .operador_a_i (operador_a_i),
        .operador_b_i (operador_b_i),
        .a_o          (a_o),
        .b_o          (b_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .resultado_i  (resultado_i),
        .wr_en_o      (wr_en_o),
        .wr_addr_o    (wr_addr_o),
        .wr_data_o    (wr_data_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".addr"},    addr_o,    0);
        chk({tag, ".a"},       a_o,       0);
        chk({tag, ".b"},       b_o,       0);
        chk({tag, ".valid"},   valid_o,   0);
        chk({tag, ".wr_en"},   wr_en_o,   0);
        chk({tag, ".wr_addr"}, wr_addr_o, 0);
        chk({tag, ".wr_data"}, wr_data_o, 0);
        chk({tag, ".busy"},    busy_o,    0);
        chk({tag, ".done"},    done_o,    0);
    endtask

    // Starts a run of n entries with ready_i high and follows it to done_o,
    // checking each write against the ROM sums; a second start pulse with
    // num_i=3 is injected at cycle restart_c when restart_c > 0.
    task automatic run(input logic [3:0] n, input int restart_c, input int max_c,
                       output int nwr, output int done_c, output int busy_c);
        int exp_addr;
        exp_addr = 0;
        nwr = 0; done_c = 0; busy_c = 0;
        ready_i = 1'b1;
        start_i = 1'b1;
        num_i   = n;
        for (int c = 1; c <= max_c && done_c == 0; c++) begin
            tick;
            if (c == 1) start_i = 1'b0;
            if (c == 1 && n != 0) chk("run.fetch_addr0", addr_o, 0);
            if (restart_c > 0 && c == restart_c) begin
                start_i = 1'b1;
                num_i   = 4'd3;
            end
            if (restart_c > 0 && c == restart_c + 1) start_i = 1'b0;
            if (busy_o) busy_c++;
            if (wr_en_o) begin
                chk("run.wr_addr", wr_addr_o, exp_addr);
                chk("run.wr_data", wr_data_o, mem_a[exp_addr] + mem_b[exp_addr]);
                exp_addr++;
                nwr++;
            end
            if (done_o) done_c = c;
        end
        chk("run.done_seen", done_c != 0, 1);
    endtask

    initial begin
        int nwr, done_c, busy_c;
        for (int i = 0; i < 8; i++) begin
            mem_a[i] = 32'(i);
            mem_b[i] = 32'(10 * i);
        end

        // reset state
        #2 rst_n = 1'b0;
        #1 chk_zero("reset");
        tick;
        tick;
        @(negedge clk) rst_n = 1'b1;

        // single entry, add model
        mem_a[0] = 32'h350F6992;
        mem_b[0] = 32'h00000001;
        start_i = 1'b1; num_i = 4'd1; ready_i = 1'b1;
        tick;
        start_i = 1'b0;
        chk("one.fetch_addr",  addr_o,  0);
        chk("one.fetch_busy",  busy_o,  1);
        chk("one.fetch_valid", valid_o, 0);
        tick;
        chk("one.issue_valid", valid_o, 1);
        chk("one.issue_a",     a_o,     32'h350F6992);
        chk("one.issue_b",     b_o,     32'h00000001);
        chk("one.issue_wr_en", wr_en_o, 0);
        tick;
        chk("one.wr_en",    wr_en_o,   1);
        chk("one.wr_addr",  wr_addr_o, 0);
        chk("one.wr_data",  wr_data_o, 32'h350F6993);
        chk("one.done",     done_o,    1);
        chk("one.busy3",    busy_o,    1);
        chk("one.valid_lo", valid_o,   0);
        tick;
        chk("one.idle_busy",  busy_o,  0);
        chk("one.idle_done",  done_o,  0);
        chk("one.idle_wr_en", wr_en_o, 0);

        // full run of eight: wr_data = 11*i
        mem_a[0] = 32'd0;
        mem_b[0] = 32'd0;
        run(4'd8, 0, 40, nwr, done_c, busy_c);
        chk("full.nwr",    nwr,       8);
        chk("full.done_c", done_c,    17);
        chk("full.busy_c", busy_c,    17);
        chk("full.last_d", wr_data_o, 32'd77);
        tick;

        // backpressure: ready low for five ISSUE cycles
        mem_a[0] = 32'hDEADBEEF; mem_b[0] = 32'h12345678;
        mem_a[1] = 32'd5;        mem_b[1] = 32'd6;
        ready_i = 1'b0; start_i = 1'b1; num_i = 4'd2;
        tick;
        start_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick;
            chk("bp.valid", valid_o, 1);
            chk("bp.a",     a_o,     32'hDEADBEEF);
            chk("bp.b",     b_o,     32'h12345678);
            chk("bp.wr_en", wr_en_o, 0);
        end
        ready_i = 1'b1;
        tick;
        chk("bp.wr0_en",   wr_en_o,   1);
        chk("bp.wr0_addr", wr_addr_o, 0);
        chk("bp.wr0_data", wr_data_o, 32'hF0E21567);
        chk("bp.fetch1",   addr_o,    1);
        tick;
        chk("bp.issue1_a", a_o, 32'd5);
        tick;
        chk("bp.wr1_en",   wr_en_o,   1);
        chk("bp.wr1_addr", wr_addr_o, 1);
        chk("bp.wr1_data", wr_data_o, 32'd11);
        chk("bp.done",     done_o,    1);
        tick;
        mem_a[0] = 32'd0; mem_b[0] = 32'd0;
        mem_a[1] = 32'd1; mem_b[1] = 32'd10;

        // num_i = 0
        start_i = 1'b1; num_i = 4'd0;
        tick;
        start_i = 1'b0;
        chk("zero.done",  done_o,  1);
        chk("zero.busy",  busy_o,  1);
        chk("zero.valid", valid_o, 0);
        chk("zero.wr_en", wr_en_o, 0);
        tick;
        chk("zero.idle_busy", busy_o, 0);
        chk("zero.idle_done", done_o, 0);

        // num_i = 9 saturates to 8
        run(4'd9, 0, 40, nwr, done_c, busy_c);
        chk("sat.nwr",     nwr,       8);
        chk("sat.last_wa", wr_addr_o, 7);
        chk("sat.done_c",  done_c,    17);
        tick;

        // start while busy is ignored
        run(4'd2, 2, 40, nwr, done_c, busy_c);
        chk("rst2.nwr",    nwr,    2);
        chk("rst2.done_c", done_c, 5);
        tick;
        chk("rst2.idle", busy_o, 0);
        tick;
        chk("rst2.still_idle", busy_o, 0);

        // asynchronous reset during ISSUE of entry 4
        start_i = 1'b1; num_i = 4'd8; ready_i = 1'b1;
        tick;
        start_i = 1'b0;
        for (int k = 0; k < 9; k++) tick;
        chk("ar.issue4_valid", valid_o, 1);
        chk("ar.issue4_a",     a_o,     32'd4);
        chk("ar.issue4_b",     b_o,     32'd40);
        #2 rst_n = 1'b0;
        #1 chk_zero("ar");
        tick;
        chk("ar.held_done", done_o, 0);
        @(negedge clk) rst_n = 1'b1;
        mem_a[0] = 32'h350F6992;
        mem_b[0] = 32'h00000001;
        run(4'd1, 0, 10, nwr, done_c, busy_c);
        chk("ar.new_nwr",    nwr,       1);
        chk("ar.new_done_c", done_c,    3);
        chk("ar.new_data",   wr_data_o, 32'h350F6993);
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
